// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502 interrupt controller.
package cpu6502_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        IDLE      = 2'd1,
        PENDING   = 2'd2
    } irq_state_e;

    // Offsets from VECTOR_BASE to each vector's low byte.
    localparam logic [15:0] NMI_OFFSET   = 16'd0;
    localparam logic [15:0] RESET_OFFSET = 16'd2;
    localparam logic [15:0] IRQ_OFFSET   = 16'd4;

endpackage

// File: rtl/cpu6502_nmi_edge_detect.sv
// Falling-edge detector and sticky latch for the active-low NMI line.
module cpu6502_nmi_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic nmi_n,
    input  logic clear,
    output logic nmi_edge,
    output logic nmi_latch
);
    logic nmi_prev_q, nmi_prev_d;
    logic nmi_latch_q, nmi_latch_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        nmi_prev_d  = nmi_prev_q;
        nmi_latch_d = nmi_latch_q;
        nmi_edge    = enable && nmi_prev_q && !nmi_n;
        if (enable) begin
            nmi_prev_d = nmi_n;
        end
        // A new edge wins over a clear in the same cycle.
        if (nmi_edge) begin
            nmi_latch_d = 1'b1;
        end else if (enable && clear) begin
            nmi_latch_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            // Track the live line during reset (1 when NMI is idle) so a line
            // held low through reset cannot look like a fresh edge on release.
            nmi_prev_q  <= nmi_n;
            nmi_latch_q <= 1'b0;
        end else begin
            nmi_prev_q  <= nmi_prev_d;
            nmi_latch_q <= nmi_latch_d;
        end
    end

    assign nmi_latch = nmi_latch_q;

endmodule

// File: rtl/cpu6502_interrupt_ctrl.sv
// 6502 interrupt sequencing: reset/NMI/IRQ arbitration and vector selection.
// Optional service counter enabled by defining CPU6502_IRQ_COUNTER_EN.
module cpu6502_interrupt_ctrl
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE = 16'hFFFA
) (
    input  logic        clock,
    input  logic        cpuReset,
    input  logic        cpuClockEnable,
    input  logic        nmiN,
    input  logic        irqN,
    input  logic        irqDisable,
    input  logic        pollPoint,
    input  logic        vectorFetch,
    output logic        interruptPending,
    output logic        resetSequence,
    output logic [15:0] vectorAddress,
    output logic [15:0] serviceCount
);
    irq_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       reset_seq_q, reset_seq_d;
    logic       nmi_edge, nmi_latch, nmi_clear;
    logic       irq_active, fetch_now;

    assign fetch_now  = cpuClockEnable && vectorFetch;
    assign irq_active = cpuClockEnable && !irqN;
    // The latch is consumed only when it actually steered the fetch to the NMI vector.
    assign nmi_clear  = vectorFetch && (state_q != RESET_SEQ) && nmi_latch;

    cpu6502_nmi_edge_detect u_nmi_edge (
        .clock    (clock),
        .reset    (cpuReset),
        .enable   (cpuClockEnable),
        .nmi_n    (nmiN),
        .clear    (nmi_clear),
        .nmi_edge (nmi_edge),
        .nmi_latch(nmi_latch)
    );

    always_comb begin
        state_d = state_q;
        if (cpuClockEnable) begin
            case (state_q)
                RESET_SEQ: if (vectorFetch) state_d = IDLE;
                IDLE: begin
                    if (pollPoint && (nmi_latch || nmi_edge || (irq_active && !irqDisable))) begin
                        state_d = PENDING;
                    end
                end
                PENDING:   if (vectorFetch) state_d = IDLE;
                default:   state_d = RESET_SEQ;
            endcase
        end
        pending_d   = (state_d == PENDING);
        reset_seq_d = (state_d == RESET_SEQ);
    end

    always_ff @(posedge clock) begin
        if (cpuReset) begin
            state_q     <= RESET_SEQ;
            pending_q   <= 1'b0;
            reset_seq_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            reset_seq_q <= reset_seq_d;
        end
    end

    assign interruptPending = pending_q;
    assign resetSequence    = reset_seq_q;

    always_comb begin
        if (state_q == RESET_SEQ) begin
            vectorAddress = VECTOR_BASE + RESET_OFFSET;
        end else if (nmi_latch) begin
            vectorAddress = VECTOR_BASE + NMI_OFFSET;
        end else begin
            vectorAddress = VECTOR_BASE + IRQ_OFFSET;
        end
    end

`ifdef CPU6502_IRQ_COUNTER_EN
    logic [15:0] service_count_q, service_count_d;

    always_comb begin
        service_count_d = service_count_q;
        if (fetch_now && (state_q != RESET_SEQ)) begin
            service_count_d = service_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (cpuReset) begin
            service_count_q <= 16'd0;
        end else begin
            service_count_q <= service_count_d;
        end
    end

    assign serviceCount = service_count_q;
`else
    logic unused_fetch;
    assign unused_fetch = fetch_now;
    assign serviceCount = 16'd0;
`endif

endmodule

// File: tb/tb_cpu6502_interrupt_ctrl.sv
// Directed self-checking bench for cpu6502_interrupt_ctrl.
module tb_cpu6502_interrupt_ctrl;
    logic        clock = 1'b0;
    logic        cpuReset, cpuClockEnable, nmiN, irqN, irqDisable, pollPoint, vectorFetch;
    logic        interruptPending, resetSequence;
    logic [15:0] vectorAddress, serviceCount;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_svc  = 0;

`ifdef CPU6502_IRQ_COUNTER_EN
    localparam int COUNT_EN = 1;
`else
    localparam int COUNT_EN = 0;
`endif

    cpu6502_interrupt_ctrl #(.VECTOR_BASE(16'hFFFA)) dut (
        .clock           (clock),
        .cpuReset        (cpuReset),
        .cpuClockEnable  (cpuClockEnable),
        .nmiN            (nmiN),
        .irqN            (irqN),
        .irqDisable      (irqDisable),
        .pollPoint       (pollPoint),
        .vectorFetch     (vectorFetch),
        .interruptPending(interruptPending),
        .resetSequence   (resetSequence),
        .vectorAddress   (vectorAddress),
        .serviceCount    (serviceCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Serviced-vector bookkeeping for the optional counter.
    task automatic serviced();
        if (COUNT_EN != 0) exp_svc = (exp_svc + 1) & 16'hFFFF;
        check("svc_count", 32'(serviceCount), 32'(exp_svc));
    endtask

    initial begin
        cpuReset = 1'b1; cpuClockEnable = 1'b1; nmiN = 1'b1; irqN = 1'b1;
        irqDisable = 1'b0; pollPoint = 1'b0; vectorFetch = 1'b0;
        tick(); tick();
        check("rst_seq", 32'(resetSequence), 32'd1);
        check("rst_pend", 32'(interruptPending), 32'd0);
        check("rst_svc", 32'(serviceCount), 32'd0);
        check("rst_vec", 32'(vectorAddress), 32'hFFFC);

        // Reset vector fetch; a disabled-cycle fetch must be ignored.
        cpuReset = 1'b0; tick();
        check("rseq_hold", 32'(resetSequence), 32'd1);
        cpuClockEnable = 1'b0; vectorFetch = 1'b1; tick();
        check("fetch_no_en", 32'(resetSequence), 32'd1);
        cpuClockEnable = 1'b1;
        check("rst_fetch_vec", 32'(vectorAddress), 32'hFFFC);
        tick(); vectorFetch = 1'b0;
        check("rseq_done", 32'(resetSequence), 32'd0);
        check("rseq_no_count", 32'(serviceCount), 32'd0);

        // IRQ masked, then unmasked; deassertion must not cancel PENDING.
        irqN = 1'b0; irqDisable = 1'b1; pollPoint = 1'b1; tick();
        check("irq_masked", 32'(interruptPending), 32'd0);
        irqDisable = 1'b0; tick();
        check("irq_pend", 32'(interruptPending), 32'd1);
        pollPoint = 1'b0; irqN = 1'b1; tick();
        check("irq_sticky", 32'(interruptPending), 32'd1);
        check("irq_vec", 32'(vectorAddress), 32'hFFFE);
        vectorFetch = 1'b1; tick(); vectorFetch = 1'b0;
        check("irq_done", 32'(interruptPending), 32'd0);
        serviced();

        // One-cycle NMI pulse, later polled.
        nmiN = 1'b0; tick(); nmiN = 1'b1; tick();
        check("nmi_latched_vec", 32'(vectorAddress), 32'hFFFA);
        pollPoint = 1'b1; tick(); pollPoint = 1'b0;
        check("nmi_pend", 32'(interruptPending), 32'd1);
        vectorFetch = 1'b1;
        check("nmi_fetch_vec", 32'(vectorAddress), 32'hFFFA);
        tick(); vectorFetch = 1'b0;
        check("nmi_done", 32'(interruptPending), 32'd0);
        check("nmi_cleared", 32'(vectorAddress), 32'hFFFE);
        serviced();

        // Hijack: IRQ pending, NMI edge the cycle before the fetch.
        irqN = 1'b0; pollPoint = 1'b1; tick(); pollPoint = 1'b0; irqN = 1'b1;
        check("hij_pend", 32'(interruptPending), 32'd1);
        check("hij_pre_vec", 32'(vectorAddress), 32'hFFFE);
        nmiN = 1'b0; tick();
        vectorFetch = 1'b1;
        check("hij_vec", 32'(vectorAddress), 32'hFFFA);
        tick(); vectorFetch = 1'b0;
        check("hij_cleared", 32'(vectorAddress), 32'hFFFE);
        serviced();
        nmiN = 1'b1; tick();

        // Second edge landing in the fetch cycle keeps the latch set.
        irqN = 1'b0; pollPoint = 1'b1; tick(); pollPoint = 1'b0; irqN = 1'b1;
        nmiN = 1'b0; tick(); nmiN = 1'b1; tick();
        nmiN = 1'b0; vectorFetch = 1'b1;
        check("edge2_vec", 32'(vectorAddress), 32'hFFFA);
        tick(); vectorFetch = 1'b0;
        check("edge2_kept", 32'(vectorAddress), 32'hFFFA);
        check("edge2_idle", 32'(interruptPending), 32'd0);
        serviced();
        nmiN = 1'b1; pollPoint = 1'b1; tick(); pollPoint = 1'b0;
        check("edge2_pend", 32'(interruptPending), 32'd1);
        vectorFetch = 1'b1; tick(); vectorFetch = 1'b0;
        check("edge2_cleared", 32'(vectorAddress), 32'hFFFE);
        serviced();

        // Reset mid-PENDING with NMI held low; no NMI afterwards.
        irqN = 1'b0; pollPoint = 1'b1; tick(); pollPoint = 1'b0;
        check("pre_rst_pend", 32'(interruptPending), 32'd1);
        nmiN = 1'b0; cpuReset = 1'b1; cpuClockEnable = 1'b0; tick();
        check("mid_rst_seq", 32'(resetSequence), 32'd1);
        check("mid_rst_pend", 32'(interruptPending), 32'd0);
        check("mid_rst_svc", 32'(serviceCount), 32'd0);
        exp_svc = 0;
        cpuReset = 1'b0; cpuClockEnable = 1'b1; pollPoint = 1'b1; tick(); tick();
        check("poll_in_rseq", 32'(interruptPending), 32'd0);
        pollPoint = 1'b0; irqN = 1'b1; vectorFetch = 1'b1;
        check("rst2_vec", 32'(vectorAddress), 32'hFFFC);
        tick(); vectorFetch = 1'b0;
        check("no_nmi_after_rst", 32'(vectorAddress), 32'hFFFE);
        pollPoint = 1'b1; tick(); pollPoint = 1'b0;
        check("no_pend_after_rst", 32'(interruptPending), 32'd0);
        check("final_svc", 32'(serviceCount), 32'(exp_svc));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu6502_interrupt_ctrl.md
CPU6502_INTERRUPT_CTRL -- requirements
Module: cpu6502_interrupt_ctrl

Interface
REQ-001 Parameter: VECTOR_BASE, 16'hFFFA, address of the NMI vector low byte; RESET vector = base+2, IRQ/BRK vector = base+4.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 cpuReset  input  1  reset; synchronous, active-high.
REQ-004 cpuClockEnable  input  1  qualifies one CPU cycle; state advances only when high, except reset.
REQ-005 nmiN  input  1  NMI request, active-low, already synchronous to clock.
REQ-006 irqN  input  1  IRQ request, active-low, level, already synchronous to clock.
REQ-007 irqDisable  input  1  current I flag from the CPU status register.
REQ-008 pollPoint  input  1  CPU interrupt-poll cycle (next-to-last cycle of each instruction).
REQ-009 vectorFetch  input  1  CPU is reading the vector low byte this cycle.
REQ-010 interruptPending  output  1  CPU replaces the next opcode fetch with the BRK-style interrupt sequence.
REQ-011 resetSequence  output  1  CPU is in the reset sequence; stack writes become reads.
REQ-012 vectorAddress  output  16  vector low-byte address for the current or next vector fetch.
REQ-013 serviceCount  output  16  count of serviced NMI+IRQ vector fetches (see Configuration).

Function
REQ-014 States: RESET_SEQ, IDLE, PENDING; encoding lives in the package.
REQ-015 NMI edge: on each enabled cycle, latch nmiPrev <= nmiN; nmiLatch SHALL set when nmiPrev=1 and nmiN=0.
REQ-016 irqActive SHALL be !irqN sampled on the enabled cycle; IRQ is never latched.
REQ-017 IDLE->PENDING on enabled cycle with pollPoint=1 and (nmiLatch or edge this cycle or (irqActive and !irqDisable)).
REQ-018 PENDING->IDLE on enabled cycle with vectorFetch=1; RESET_SEQ->IDLE on the same condition.
REQ-019 interruptPending SHALL be 1 exactly in PENDING; resetSequence SHALL be 1 exactly in RESET_SEQ; both registered.
REQ-020 vectorAddress combinational: RESET_SEQ -> base+2; else nmiLatch -> base; else base+4.
REQ-021 NMI hijack: if nmiLatch sets at any time before the vectorFetch cycle, including during BRK in IDLE, that fetch SHALL use base.
REQ-022 nmiLatch SHALL clear on enabled vectorFetch while it selects base; a new falling edge in the same cycle SHALL keep it set.
REQ-023 IRQ deasserted after entering PENDING SHALL NOT cancel PENDING; the vector is base+4.
REQ-024 vectorFetch with cpuClockEnable=0 SHALL be ignored; pollPoint in PENDING or RESET_SEQ SHALL be ignored.
REQ-025 All arithmetic on VECTOR_BASE wraps modulo 2^16.

Reset
REQ-026 cpuReset SHALL override every other input, mid-sequence included, with no dependence on cpuClockEnable.
REQ-027 Reset values: state=RESET_SEQ, nmiLatch=0, nmiPrev=1, interruptPending=0, resetSequence=1, serviceCount=0.
REQ-028 NMI held low through reset SHALL NOT produce an edge on release.

Configuration
REQ-029 Macro CPU6502_IRQ_COUNTER_EN: when defined, serviceCount SHALL increment, wrapping at 16'hFFFF->0, on each enabled vectorFetch in PENDING or BRK-in-IDLE; reset-sequence fetches SHALL NOT count.
REQ-030 When the macro is undefined, serviceCount SHALL be constant 0 and the counter SHALL not be synthesized.

Structure
REQ-031 Package cpu6502_pkg SHALL hold the state enum and the NMI/RESET/IRQ vector offset constants (0, 2, 4).
REQ-032 One sub-module, cpu6502_nmi_edge_detect, SHALL hold nmiPrev/nmiLatch with set, clear and reset inputs.

Verification
REQ-033 Reset then vectorFetch -> vectorAddress=16'hFFFC and resetSequence=1 before the fetch; resetSequence=0 after it.
REQ-034 irqN=0, irqDisable=0, pollPoint -> interruptPending=1 next cycle; fetch at 16'hFFFE; irqDisable=1 -> no pending.
REQ-035 nmiN 1->0 pulse of one enabled cycle, then pollPoint -> PENDING; fetch at 16'hFFFA; nmiLatch clears.
REQ-036 IRQ in PENDING, NMI edge one cycle before vectorFetch -> fetch at 16'hFFFA (hijack); a second edge in the fetch cycle stays latched.
REQ-037 cpuReset asserted in PENDING with nmiN held 0 -> RESET_SEQ; after release, no NMI pending.
REQ-038 With CPU6502_IRQ_COUNTER_EN, serviceCount preloaded to 16'hFFFF then one serviced IRQ -> 16'h0000; without the macro -> always 0.
